// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bundle shared by the upstream and downstream sides of the pattern generator.
interface axis_video_pattern_gen_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video source: upstream passthrough or synthesised bars/ramp/tag frames with
// line and frame blanking. Mode and enable are only sampled between lines/frames.
module axis_video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 32,
    parameter int H_GAP    = 16,
    parameter int V_GAP    = 64,
    parameter int BAR_W    = 80
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    axis_video_pattern_gen_if.slave       s_axis_video,
    axis_video_pattern_gen_if.master      m_axis_video,
    output logic [15:0]                   frame_cnt,
    output logic                          busy
);
    localparam int X_W     = $clog2(H_ACTIVE);
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int GAP_MAX = (H_GAP > V_GAP) ? H_GAP : V_GAP;
    localparam int G_W     = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam int B_W     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [X_W-1:0] X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);
    localparam logic [G_W-1:0] HG_LAST = G_W'((H_GAP > 0) ? H_GAP - 1 : 0);
    localparam logic [G_W-1:0] VG_LAST = G_W'((V_GAP > 0) ? V_GAP - 1 : 0);
    localparam logic [B_W-1:0] B_LAST  = B_W'(BAR_W - 1);

    typedef enum logic [2:0] {IDLE, PASS, LINE, HGAP, VGAP} state_t;

    state_t             state, state_n;
    logic [1:0]         mode_q, mode_n;
    logic [X_W-1:0]     x, x_n;
    logic [Y_W-1:0]     y, y_n;
    logic [G_W-1:0]     gap, gap_n;
    logic [B_W-1:0]     bar_cnt, bar_cnt_n;
    logic [2:0]         bar_idx, bar_idx_n;
    logic [15:0]        fc_n;
    logic               hs;
    logic [23:0]        pix;
    logic [DATA_W-1:0]  tdata_q, tdata_n;
    logic               tvalid_q, tuser_q, tlast_q;
    logic               pass;

    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        x_n       = x;
        y_n       = y;
        gap_n     = gap;
        bar_cnt_n = bar_cnt;
        bar_idx_n = bar_idx;
        fc_n      = frame_cnt;
        hs        = tvalid_q & m_axis_video.tready;

        case (state)
            IDLE: begin
                mode_n    = mode;
                x_n       = '0;
                y_n       = '0;
                bar_cnt_n = '0;
                bar_idx_n = '0;
                if (mode == 2'd0)
                    state_n = PASS;
                else if (enable)
                    state_n = LINE;
            end
            PASS: begin
                if (s_axis_video.tvalid && m_axis_video.tready && s_axis_video.tlast)
                    state_n = IDLE;
            end
            LINE: begin
                if (hs) begin
                    if (x == X_LAST) begin
                        x_n       = '0;
                        bar_cnt_n = '0;
                        bar_idx_n = '0;
                        gap_n     = '0;
                        if (y == Y_LAST) begin
                            y_n     = '0;
                            fc_n    = frame_cnt + 16'd1;
                            state_n = (V_GAP == 0) ? IDLE : VGAP;
                        end else begin
                            y_n     = y + 1'b1;
                            state_n = (H_GAP == 0) ? LINE : HGAP;
                        end
                    end else begin
                        x_n = x + 1'b1;
                        if (bar_cnt == B_LAST) begin
                            bar_cnt_n = '0;
                            bar_idx_n = bar_idx + 3'd1;
                        end else begin
                            bar_cnt_n = bar_cnt + 1'b1;
                        end
                    end
                end
            end
            HGAP: begin
                if (gap == HG_LAST)
                    state_n = LINE;
                else
                    gap_n = gap + 1'b1;
            end
            VGAP: begin
                if (gap == VG_LAST)
                    state_n = IDLE;
                else
                    gap_n = gap + 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Pixel is built from next-state counters so the output register holds the beat on display.
        case (mode_n)
            2'd1:    pix = {{8{~bar_idx_n[1]}}, {8{~bar_idx_n[2]}}, {8{~bar_idx_n[0]}}};
            2'd2:    pix = {3{8'(x_n)}};
            2'd3:    pix = {fc_n[7:0], 8'(y_n), 8'(x_n)};
            default: pix = '0;
        endcase

        tdata_n = '0;
        if (state_n == LINE)
            tdata_n[23:0] = pix;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mode_q    <= '0;
            x         <= '0;
            y         <= '0;
            gap       <= '0;
            bar_cnt   <= '0;
            bar_idx   <= '0;
            frame_cnt <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tuser_q   <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            x         <= x_n;
            y         <= y_n;
            gap       <= gap_n;
            bar_cnt   <= bar_cnt_n;
            bar_idx   <= bar_idx_n;
            frame_cnt <= fc_n;
            tdata_q   <= tdata_n;
            tvalid_q  <= (state_n == LINE);
            tuser_q   <= (state_n == LINE) && (x_n == '0) && (y_n == '0);
            tlast_q   <= (state_n == LINE) && (x_n == X_LAST);
        end
    end

    assign pass = (state == PASS);

    assign m_axis_video.tdata  = pass ? s_axis_video.tdata  : tdata_q;
    assign m_axis_video.tvalid = pass ? s_axis_video.tvalid : tvalid_q;
    assign m_axis_video.tuser  = pass ? s_axis_video.tuser  : tuser_q;
    assign m_axis_video.tlast  = pass ? s_axis_video.tlast  : tlast_q;
    assign s_axis_video.tready = pass & m_axis_video.tready;
    assign busy                = (state != IDLE);
endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Scoreboard bench for axis_video_pattern_gen: directed scenarios push expected beats,
// an independent monitor pops and compares on every downstream handshake.
`timescale 1ns/1ps
module tb_axis_video_pattern_gen;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HG = 2;
    localparam int VG = 3;
    localparam int BW = 1;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd1;
    logic [15:0] frame_cnt;
    logic        busy;

    axis_video_pattern_gen_if #(.DATA_W(DW)) s_if ();
    axis_video_pattern_gen_if #(.DATA_W(DW)) m_if ();

    axis_video_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .H_GAP(HG), .V_GAP(VG), .BAR_W(BW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .mode         (mode),
        .s_axis_video (s_if),
        .m_axis_video (m_if),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    beat_t q[$];
    beat_t e;
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_fc = 0;
    int    tr_mode = 0;
    bit    chk_gap = 1'b0;
    int    cyc = 0;
    int    last_cyc = 0;
    bit    have_last = 1'b0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int m, input int x, input int y, input int fc);
        logic [7:0] xb, yb, fb;
        xb = x[7:0];
        yb = y[7:0];
        fb = fc[7:0];
        case (m)
            1:       return {8'h00, bars[(x / BW) % 8]};
            2:       return {8'h00, xb, xb, xb};
            3:       return {8'h00, fb, yb, xb};
            default: return 32'h0;
        endcase
    endfunction

    task automatic push_beat(input logic [31:0] d, input logic u, input logic l);
        beat_t b;
        b.data = d;
        b.user = u;
        b.last = l;
        q.push_back(b);
    endtask

    task automatic push_frame(input int m, input int fc);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                push_beat(exp_pix(m, x, y, fc), (x == 0 && y == 0), (x == H - 1));
    endtask

    task automatic start_gen(input int m);
        @(posedge clk); #1;
        mode = 2'(m);
        enable = 1'b1;
        @(negedge clk);
        check("start_idle", m_if.tvalid, 0);
        @(negedge clk);
        check("start_sof", {m_if.tvalid, m_if.tuser}, 2'b11);
    endtask

    task automatic finish_gen(input int nfr);
        logic [15:0] target;
        target = 16'(exp_fc + nfr);
        for (int i = 0; i < 2000 && frame_cnt != target; i++) @(negedge clk);
        check("fc_reach", frame_cnt, target);
        @(posedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("idle", busy, 0);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        check("drain", q.size(), 0);
        exp_fc = target;
        chk_gap = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_fc = 0;
    endtask

    // Downstream ready driver: 0 = held high, 1 = 1,0,0,1 pattern, 2 = held low
    initial begin
        int k;
        k = 0;
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (tr_mode)
                1: begin
                    m_if.tready = (k % 4 == 0) || (k % 4 == 3);
                    k++;
                end
                2:       m_if.tready = 1'b0;
                default: m_if.tready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!chk_gap) have_last = 1'b0;
        if (rstn && m_if.tvalid && m_if.tready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got %0h with nothing expected at %0t", m_if.tdata, $time);
            end else begin
                e = q.pop_front();
                check("beat", {m_if.tuser, m_if.tlast, m_if.tdata}, {e.user, e.last, e.data});
            end
            if (have_last) begin
                check("gap", cyc - last_cyc, m_if.tuser ? VG + 2 : HG + 1);
                have_last = 1'b0;
            end
            if (chk_gap && m_if.tlast) begin
                have_last = 1'b1;
                last_cyc = cyc;
            end
        end else if (rstn && m_if.tvalid && tr_mode == 1 && q.size() > 0) begin
            check("stall_hold", {m_if.tuser, m_if.tlast, m_if.tdata}, {q[0].user, q[0].last, q[0].data});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, 0);
        check("rst_fc", frame_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_if.tready, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Colour bars, single frame
        chk_gap = 1'b1;
        push_frame(1, 0);
        start_gen(1);
        finish_gen(1);

        // Tag mode across two back-to-back frames
        do_reset();
        chk_gap = 1'b1;
        push_frame(3, 0);
        push_frame(3, 1);
        start_gen(3);
        finish_gen(2);

        // Ramp under backpressure
        tr_mode = 1;
        push_frame(2, exp_fc);
        start_gen(2);
        finish_gen(1);
        tr_mode = 0;

        // Passthrough then switch to bars at the upstream line end
        @(posedge clk); #1;
        mode = 2'd0;
        @(posedge clk); #1;
        tr_mode = 2;
        s_if.tdata = 32'hA; s_if.tvalid = 1'b1; s_if.tuser = 1'b1; s_if.tlast = 1'b0;
        push_beat(32'hA, 1'b1, 1'b0);
        push_beat(32'hB, 1'b0, 1'b0);
        push_beat(32'hC, 1'b0, 1'b1);
        @(negedge clk);
        check("pass_busy", busy, 1);
        check("pass_stall", {s_if.tready, m_if.tvalid, m_if.tdata}, {1'b0, 1'b1, 32'hA});
        @(posedge clk); #1;
        tr_mode = 0;
        @(negedge clk);
        check("pass_a", {s_if.tready, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, 1'b1, 1'b0, 32'hA});
        @(posedge clk); #1;
        s_if.tdata = 32'hB; s_if.tuser = 1'b0;
        @(negedge clk);
        check("pass_b", {s_if.tready, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, 1'b0, 1'b0, 32'hB});
        @(posedge clk); #1;
        s_if.tdata = 32'hC; s_if.tlast = 1'b1;
        mode = 2'd1;
        enable = 1'b1;
        push_frame(1, exp_fc);
        @(negedge clk);
        check("pass_c", {s_if.tready, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, 1'b0, 1'b1, 32'hC});
        @(posedge clk); #1;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        finish_gen(1);

        // Mid-frame mode/enable change must not disturb the running frame
        do_reset();
        push_frame(1, 0);
        start_gen(1);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        mode = 2'd2;
        enable = 1'b0;
        finish_gen(1);
        repeat (10) @(negedge clk);
        check("hold_idle", {busy, m_if.tvalid}, 2'b00);
        check("hold_fc", frame_cnt, 1);

        // Asynchronous reset at x=4 of line 1
        for (int x = 0; x < H; x++) push_beat(exp_pix(2, x, 0, 0), (x == 0), (x == H - 1));
        for (int x = 0; x < 4; x++) push_beat(exp_pix(2, x, 1, 0), 1'b0, 1'b0);
        @(posedge clk); #1;
        mode = 2'd2;
        enable = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("pre_rst_pix", {m_if.tvalid, m_if.tdata}, {1'b1, 32'h00040404});
        rstn = 1'b0;
        #1;
        check("async_rst_m", {m_if.tvalid, m_if.tuser, m_if.tlast}, 3'b000);
        check("async_rst_fc", frame_cnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_q", q.size(), 0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_fc = 0;
        push_frame(2, 0);
        start_gen(2);
        finish_gen(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axis_video_pattern_gen.md
# axis_video_pattern_gen

Parametrised AXI4-Stream video source that drives the transmit memory's video input with either a bypassed upstream stream or a synthesised test frame. It supports:
- configurable frame geometry, pixel width and blanking gaps;
- four runtime modes, selected at line/frame boundaries;
- full downstream backpressure.

It sits between the camera/VDMA stream and the transmit frame buffer, replacing the fixed single-pattern generator.

## Interface
- H_ACTIVE, 640: pixels per line (≥2)
- V_ACTIVE, 480: lines per frame (≥1)
- DATA_W, 32: tdata width (≥24); pixel in bits [23:0] as {R,G,B}, upper bits zero
- H_GAP, 16: idle cycles after each non-final line (0 allowed)
- V_GAP, 64: idle cycles after the final line of a frame (0 allowed)
- BAR_W, 80: color-bar width in pixels (≥1)

- clk  in  1  clock, all logic rising-edge
- rstn  in  1  asynchronous, active-low reset
- enable  in  1  start/continue frame generation; sampled only in IDLE
- mode  in  2  0 passthrough, 1 color bars, 2 ramp, 3 coordinate/frame tag; sampled only in IDLE
- s_axis_video_tdata  in  DATA_W  upstream pixel
- s_axis_video_tvalid  in  1  upstream valid
- s_axis_video_tready  out  1  upstream ready
- s_axis_video_tuser  in  1  upstream start-of-frame
- s_axis_video_tlast  in  1  upstream end-of-line
- m_axis_video_tdata  out  DATA_W  output pixel
- m_axis_video_tvalid  out  1  output valid
- m_axis_video_tready  in  1  output ready
- m_axis_video_tuser  out  1  start-of-frame, first pixel of frame only
- m_axis_video_tlast  out  1  end-of-line, pixel x=H_ACTIVE-1
- frame_cnt  out  16  completed synthetic frames, wraps 0xFFFF→0
- busy  out  1  high in every state except IDLE

## Operation

**States:** IDLE, PASS, LINE, HGAP, VGAP.

**IDLE**
- mode_q<=mode.
- If mode==0 → PASS.
- Else if enable → LINE with x=0, y=0.
- Else stay.

**PASS**
- m_axis_* = s_axis_* and s_axis_video_tready = m_axis_video_tready, combinationally.
- On an accepted beat with s tlast=1 → IDLE, so mode is re-sampled at each upstream line end.
- enable is ignored in PASS.
- Outside PASS, s_axis_video_tready=0.

**LINE**
- m tvalid=1.
- On handshake (tvalid&tready), x++.
- On the handshake of x=H_ACTIVE-1:
  - if y=V_ACTIVE-1: → VGAP, and frame_cnt++ on that edge;
  - else: y++, → HGAP, or directly → LINE with x=0 if H_GAP=0.

**HGAP**
- Counter runs H_GAP cycles, then → LINE with x=0.

**VGAP**
- Counter runs V_GAP cycles, then → IDLE; V_GAP=0 goes straight to IDLE.

**Pixel patterns** (index i = bar count, counting up every BAR_W pixels, wrapping mod 8, reset to 0 at x=0):
- **Mode 1, color bars:**
  - R=FF if i∈{0,1,4,5}, else 00;
  - G=FF if i∈{0,1,2,3}, else 00;
  - B=FF if i even, else 00;
  - giving white, yellow, cyan, green, magenta, red, blue, black.
- **Mode 2, ramp:** R=G=B=x[7:0].
- **Mode 3, tag:** {R,G,B} = {frame_cnt[7:0], y[7:0], x[7:0]}.

**Sideband and mode rules:**
- tuser=1 only while x=0 and y=0; tlast=1 only while x=H_ACTIVE-1.
- A mode or enable change mid-frame has no effect until IDLE; frames are never truncated.
- enable deasserted during a frame: the frame completes, then the block stays in IDLE.

**Widths:**
- x, y counters are clog2(H_ACTIVE) and clog2(V_ACTIVE) bits, never exceeding the active limits.
- Gap counter width fits max(H_GAP, V_GAP).
- Bar counter fits BAR_W.

## Timing
- **Reset values:**
  - state IDLE, mode_q 0, x=y=0, frame_cnt 0;
  - m tvalid/tuser/tlast 0, m tdata 0, busy 0.
- **Registered outputs** in generated modes; PASS is a zero-latency combinational path.
- **Start latency:** enable=1 with mode≠0 sampled in IDLE at edge N. State becomes LINE at edge N+1, with tvalid=1 and tuser=1 and pixel (0,0) valid after N+1.
- **AXI rule:** while tvalid=1 and tready=0, tdata/tuser/tlast are held stable and x does not advance. tvalid never drops inside LINE.
- **Line period:** with tready held 1, the period is H_ACTIVE+H_GAP cycles and the frame period is V_ACTIVE·H_ACTIVE + (V_ACTIVE−1)·H_GAP + V_GAP + 1 (IDLE) cycles.
- **Gap counting:** gaps count clock cycles regardless of tready.
- **Reset mid-frame:** rstn low forces the reset values asynchronously; after release the block restarts from IDLE with x=y=0.
- **Back-to-back frames:** with enable held, the next frame's tuser appears V_GAP+2 cycles after the last tlast handshake.

## Test plan
Parameters for all scenarios: H_ACTIVE=8, V_ACTIVE=4, H_GAP=2, V_GAP=3, BAR_W=1, DATA_W=32.

1. **Color bars:** mode=1, enable=1, tready=1.
   - Line 0 tdata = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
   - tuser only on the first beat, tlast on the 8th beat, 2 idle cycles between lines.
   - frame_cnt=1 after 32 beats.
2. **Tag mode across frames:** mode=3, two frames.
   - Frame 0 beat (x=5, y=2) = 0x00000205.
   - Frame 1 first beat = 0x00010000.
   - Frame 1 tuser occurs V_GAP+2 = 5 cycles after frame 0's last tlast handshake.
3. **Backpressure:** mode=2, tready toggles 1,0,0,1 repeating.
   - tdata stays stable while stalled.
   - The accepted sequence is exactly 00..07 per line, with no skips or duplicates.
4. **Passthrough:** mode=0, drive 3 upstream beats (0xA, 0xB, 0xC with tlast).
   - Outputs match in the same cycle and s tready equals m tready.
   - After the tlast beat, mode=1 is sampled and synthetic frame generation starts.
5. **Mid-frame changes:** during frame 0 (mode=1), switch to mode=2 and drop enable.
   - Frame 0 completes as bars.
   - The block then stays in IDLE with busy=0 and frame_cnt=1.
6. **Reset mid-line:** assert rstn=0 at x=4 of line 1.
   - tvalid, tuser, tlast and frame_cnt are 0 immediately.
   - After release, with enable=1, the first beat is pixel (0,0) with tuser=1.
